// File: rtl/reg_op_sequencer_pkg.sv
// Shared opcode, FunSel and state encodings for the register-bank command sequencer.
package reg_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_INC   = 3'b001;
  localparam logic [2:0] OP_DEC   = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_LOADW = 3'b100;
  localparam logic [2:0] OP_MOVE  = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_ADDK  = 3'b111;

  // FunSel codes understood by the Register instances; 3'b111 is never used.
  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_LOADL = 3'b100;
  localparam logic [2:0] FS_LOADH = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_EXEC2  = 2'd2,
    ST_REPEAT = 2'd3
  } state_e;

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command handshake plus register-bank drive bundle between control unit, sequencer and bank.
interface reg_op_sequencer_if
  import reg_ctrl_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int WIDTH = 16
);

  // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready are both 1;
  // cmd_* are ignored at every other edge, including all edges while busy is 1.
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_op;
  logic [1:0]             cmd_dst;
  logic [1:0]             cmd_src;
  logic [WIDTH-1:0]       cmd_data;
  logic [NREG*WIDTH-1:0]  RegQ;
  logic [NREG-1:0]        RegE;
  logic [2:0]             FunSel;
  logic [WIDTH-1:0]       RegI;
  logic                   busy;
  logic                   done;
  state_e                 dbg_state;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, RegQ,
    output cmd_ready, RegE, FunSel, RegI, busy, done, dbg_state
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_data, RegQ,
    input  cmd_ready, RegE, FunSel, RegI, busy, done, dbg_state
  );

endinterface

// File: rtl/reg_op_sequencer_rep_counter.sv
// 4-bit loadable down-counter; last_o marks the final repeat cycle of an ADDK burst.
module rep_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  logic [3:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == 4'd1);

endmodule

// File: rtl/reg_op_sequencer.sv
// Expands one accepted command into per-cycle RegE/FunSel/RegI drive for a shared-bus register bank.
module reg_op_sequencer
  import reg_ctrl_pkg::*;
#(
  parameter int NREG  = 4,
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  reg_op_sequencer_if.slave  bus
);

  typedef struct packed {
    logic [NREG-1:0]  e;
    logic [2:0]       fs;
    logic [WIDTH-1:0] i;
    logic             done;
  } drive_t;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       dst_q, dst_d, src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d, sv_q, sv_d, dv_q, dv_d;
  drive_t           drv_q, drv_d;
  logic             busy_q, busy_d, ready_q, ready_d;
  logic             accept;
  logic [3:0]       rep_cnt;
  logic             rep_last;

  // Out-of-range indices simply produce no enable.
  function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
    logic [NREG-1:0] r;
    r = '0;
    for (int k = 0; k < NREG; k++) begin
      if (k == int'(idx)) r[k] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [NREG*WIDTH-1:0] q, input logic [1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NREG; k++) begin
      if (k == int'(idx)) r = q[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign accept = bus.cmd_valid && ready_q;

  rep_counter u_rep_counter (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .load_i     (accept),
    .load_val_i (bus.cmd_data[3:0]),
    .dec_i      ((state_q == ST_EXEC1) || (state_q == ST_REPEAT)),
    .count_o    (rep_cnt),
    .last_o     (rep_last)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    src_d   = src_q;
    data_d  = data_q;
    sv_d    = sv_q;
    dv_d    = dv_q;
    if (accept) begin
      op_d   = bus.cmd_op;
      dst_d  = bus.cmd_dst;
      src_d  = bus.cmd_src;
      data_d = bus.cmd_data;
      sv_d   = pick(bus.RegQ, bus.cmd_src);
      dv_d   = pick(bus.RegQ, bus.cmd_dst);
    end

    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_EXEC1;
      ST_EXEC1: begin
        if ((op_q == OP_LOADW) || (op_q == OP_SWAP))           state_d = ST_EXEC2;
        else if ((op_q == OP_ADDK) && (data_q[3:0] >= 4'd2))  state_d = ST_REPEAT;
        else                                                  state_d = ST_IDLE;
      end
      ST_EXEC2:  state_d = ST_IDLE;
      ST_REPEAT: if (rep_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);

    // Outputs are registered, so decode the cycle we are about to enter.
    drv_d.e    = '0;
    drv_d.fs   = FS_LOAD;
    drv_d.i    = '0;
    drv_d.done = 1'b0;
    unique case (state_d)
      ST_EXEC1: begin
        unique case (op_d)
          OP_NOP: drv_d.done = 1'b1;
          OP_INC: begin drv_d.e = onehot(dst_d); drv_d.fs = FS_INC; drv_d.done = 1'b1; end
          OP_DEC: begin drv_d.e = onehot(dst_d); drv_d.fs = FS_DEC; drv_d.done = 1'b1; end
          OP_CLR: begin drv_d.e = onehot(dst_d); drv_d.fs = FS_CLR; drv_d.done = 1'b1; end
          OP_LOADW: begin
            drv_d.e  = onehot(dst_d);
            drv_d.fs = FS_LOADL;
            drv_d.i  = {8'h00, data_d[7:0]};
          end
          OP_MOVE: begin
            drv_d.e    = onehot(dst_d);
            drv_d.i    = sv_d;
            drv_d.done = 1'b1;
          end
          OP_SWAP: begin
            drv_d.e = onehot(dst_d);
            drv_d.i = sv_d;
          end
          OP_ADDK: begin
            if (data_d[3:0] != 4'd0) begin
              drv_d.e  = onehot(dst_d);
              drv_d.fs = FS_INC;
            end
            drv_d.done = (data_d[3:0] <= 4'd1);
          end
          default: drv_d.done = 1'b1;
        endcase
      end
      ST_EXEC2: begin
        drv_d.done = 1'b1;
        if (op_d == OP_LOADW) begin
          drv_d.e  = onehot(dst_d);
          drv_d.fs = FS_LOADH;
          drv_d.i  = {8'h00, data_d[15:8]};
        end else begin
          drv_d.e = onehot(src_d);
          drv_d.i = dv_d;
        end
      end
      ST_REPEAT: begin
        // The counter decrements on this edge, so a current count of 2 means the next cycle is last.
        drv_d.e    = onehot(dst_d);
        drv_d.fs   = FS_INC;
        drv_d.done = (rep_cnt == 4'd2);
      end
      default: ;
    endcase
    if (drv_d.e == '0) drv_d.fs = FS_LOAD;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      dst_q      <= 2'd0;
      src_q      <= 2'd0;
      data_q     <= '0;
      sv_q       <= '0;
      dv_q       <= '0;
      drv_q.e    <= '0;
      drv_q.fs   <= FS_LOAD;
      drv_q.i    <= '0;
      drv_q.done <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      data_q  <= data_d;
      sv_q    <= sv_d;
      dv_q    <= dv_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.RegE      = drv_q.e;
  assign bus.FunSel    = drv_q.fs;
  assign bus.RegI      = drv_q.i;
  assign bus.busy      = busy_q;
  assign bus.done      = drv_q.done;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: behavioural register bank, directed scenarios, then random commands.
module tb_reg_op_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_op_sequencer_if bus ();

  reg_op_sequencer dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // ---------------- register bank (environment) ----------------
  logic [15:0] bank [4];
  logic        pre_en;
  logic [1:0]  pre_idx;
  logic [15:0] pre_val;

  always @(posedge clk) begin
    if (pre_en) bank[pre_idx] <= pre_val;
    else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.RegE[k]) begin
          case (bus.FunSel)
            3'b000:  bank[k] <= bank[k] - 16'd1;
            3'b001:  bank[k] <= bank[k] + 16'd1;
            3'b010:  bank[k] <= bus.RegI;
            3'b011:  bank[k] <= 16'h0000;
            3'b100:  bank[k] <= {bank[k][15:8], bus.RegI[7:0]};
            3'b110:  bank[k] <= {bus.RegI[7:0], bank[k][7:0]};
            default: ;
          endcase
        end
      end
    end
  end

  always_comb bus.RegQ = {bank[3], bank[2], bank[1], bank[0]};

  // ---------------- reference model + scoreboard ----------------
  logic [15:0] mdl [4];
  logic [23:0] exp_q [$];
  int tests_run = 0;
  int fails = 0;
  string op_names [8] = '{"NOP", "INC", "DEC", "CLR", "LOADW", "MOVE", "SWAP", "ADDK"};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RegI only matters for load-type FunSel codes with an enable present.
  function automatic logic [23:0] rec(input logic [3:0] e, input logic [2:0] fs,
                                      input logic [15:0] i, input logic d);
    logic [15:0] iv;
    iv = i;
    if (e == 4'd0 || fs == 3'b000 || fs == 3'b001 || fs == 3'b011) iv = 16'h0000;
    return {e, fs, iv, d};
  endfunction

  function automatic logic [63:0] bank_all();
    return {bank[3], bank[2], bank[1], bank[0]};
  endfunction

  function automatic logic [63:0] mdl_all();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preset(input int idx, input logic [15:0] v);
    pre_en  = 1'b1;
    pre_idx = idx[1:0];
    pre_val = v;
    mdl[idx] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                         input logic [15:0] data, input bit hold, input logic [2:0] nop,
                         input logic [1:0] ndst, input logic [15:0] ndata, output int waited);
    logic [15:0] sv, dv;
    logic [3:0]  oh_d, oh_s;
    logic [23:0] obs;
    logic        ok;
    int          n, exp_len, cyc;
    string       nm;
    nm   = op_names[op];
    sv   = mdl[src];
    dv   = mdl[dst];
    oh_d = 4'b0001 << dst;
    oh_s = 4'b0001 << src;
    exp_q.delete();
    case (op)
      3'd0: exp_q.push_back(rec(4'd0, 3'b010, 16'h0, 1'b1));
      3'd1: exp_q.push_back(rec(oh_d, 3'b001, 16'h0, 1'b1));
      3'd2: exp_q.push_back(rec(oh_d, 3'b000, 16'h0, 1'b1));
      3'd3: exp_q.push_back(rec(oh_d, 3'b011, 16'h0, 1'b1));
      3'd4: begin
        exp_q.push_back(rec(oh_d, 3'b100, {8'h00, data[7:0]}, 1'b0));
        exp_q.push_back(rec(oh_d, 3'b110, {8'h00, data[15:8]}, 1'b1));
      end
      3'd5: exp_q.push_back(rec(oh_d, 3'b010, sv, 1'b1));
      3'd6: begin
        exp_q.push_back(rec(oh_d, 3'b010, sv, 1'b0));
        exp_q.push_back(rec(oh_s, 3'b010, dv, 1'b1));
      end
      default: begin
        n = int'(data[3:0]);
        if (n == 0) exp_q.push_back(rec(4'd0, 3'b010, 16'h0, 1'b1));
        for (int j = 0; j < n; j++) exp_q.push_back(rec(oh_d, 3'b001, 16'h0, j == n - 1));
      end
    endcase
    exp_len = exp_q.size();

    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src   = src;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({nm, "_ready_seen"}, 64'(waited < 20), 64'd1);
    if (waited >= 20) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (hold) begin
      bus.cmd_op   = nop;
      bus.cmd_dst  = ndst;
      bus.cmd_data = ndata;
    end else bus.cmd_valid = 1'b0;

    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      obs = rec(bus.RegE, bus.FunSel, bus.RegI, bus.done);
      if (exp_q.size() > 0) check({nm, "_step"}, 64'(obs), 64'(exp_q.pop_front()));
      ok = (bus.FunSel != 3'b111) && $onehot0(bus.RegE) &&
           (bus.RegE != 4'd0 || bus.FunSel == 3'b010);
      check({nm, "_invariant"}, 64'(ok), 64'd1);
      if (!hold) begin
        bus.cmd_op   = 3'($urandom);
        bus.cmd_dst  = 2'($urandom);
        bus.cmd_src  = 2'($urandom);
        bus.cmd_data = 16'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    check({nm, "_exec_cycles"}, 64'(cyc), 64'(exp_len));

    case (op)
      3'd1: mdl[dst] = mdl[dst] + 16'd1;
      3'd2: mdl[dst] = mdl[dst] - 16'd1;
      3'd3: mdl[dst] = 16'h0000;
      3'd4: mdl[dst] = data;
      3'd5: mdl[dst] = sv;
      3'd6: begin mdl[dst] = sv; mdl[src] = dv; end
      3'd7: mdl[dst] = mdl[dst] + 16'(data[3:0]);
      default: ;
    endcase
    check({nm, "_regs"}, bank_all(), mdl_all());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    logic [2:0]  rop;
    logic [15:0] rdata;
    rst_n         = 1'b0;
    pre_en        = 1'b0;
    pre_idx       = 2'd0;
    pre_val       = 16'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_dst   = 2'd0;
    bus.cmd_src   = 2'd0;
    bus.cmd_data  = 16'h0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) preset(k, 16'h1111 * 16'(k + 1));
    check("rst_RegE",   64'(bus.RegE),      64'd0);
    check("rst_FunSel", 64'(bus.FunSel),    64'(3'b010));
    check("rst_RegI",   64'(bus.RegI),      64'd0);
    check("rst_busy",   64'(bus.busy),      64'd0);
    check("rst_done",   64'(bus.done),      64'd0);
    check("rst_ready",  64'(bus.cmd_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted during the first SWAP execute cycle
    preset(0, 16'h5555);
    preset(1, 16'hAAAA);
    bus.cmd_op = 3'd6; bus.cmd_dst = 2'd0; bus.cmd_src = 2'd1; bus.cmd_data = 16'h0;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    check("t1_ready_seen", 64'(w < 20), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t1_exec1_RegE", 64'(bus.RegE), 64'(4'b0001));
    rst_n = 1'b0;
    #1;
    check("t1_abort_RegE",   64'(bus.RegE),      64'd0);
    check("t1_abort_FunSel", 64'(bus.FunSel),    64'(3'b010));
    check("t1_abort_busy",   64'(bus.busy),      64'd0);
    check("t1_abort_ready",  64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_ready_after", 64'(bus.cmd_ready), 64'd1);
    check("t1_regs_untouched", bank_all(), mdl_all());

    // LOADW byte pair
    preset(2, 16'h0000);
    run_cmd(3'd4, 2'd2, 2'd0, 16'hBEEF, 1'b0, 3'd0, 2'd0, 16'h0, w);
    check("t2_R2", 64'(bank[2]), 64'(16'hBEEF));

    // SWAP of two distinct registers
    preset(0, 16'h1234);
    preset(1, 16'hABCD);
    run_cmd(3'd6, 2'd0, 2'd1, 16'h0, 1'b0, 3'd0, 2'd0, 16'h0, w);
    check("t3_R0", 64'(bank[0]), 64'(16'hABCD));
    check("t3_R1", 64'(bank[1]), 64'(16'h1234));

    // ADDK wrapping through zero
    preset(3, 16'hFFFE);
    run_cmd(3'd7, 2'd3, 2'd0, 16'h0003, 1'b0, 3'd0, 2'd0, 16'h0, w);
    check("t4_R3", 64'(bank[3]), 64'(16'h0001));

    // ADDK N=0 then INC with cmd_valid held high throughout
    run_cmd(3'd7, 2'd1, 2'd0, 16'h0000, 1'b1, 3'd1, 2'd1, 16'h0, w);
    check("t5_idle_busy",  64'(bus.busy),      64'd0);
    check("t5_idle_ready", 64'(bus.cmd_ready), 64'd1);
    run_cmd(3'd1, 2'd1, 2'd0, 16'h0, 1'b0, 3'd0, 2'd0, 16'h0, w);
    check("t5_inc_wait", 64'(w), 64'd0);

    // MOVE onto itself, then NOP
    preset(1, 16'h5A5A);
    run_cmd(3'd5, 2'd1, 2'd1, 16'h0, 1'b0, 3'd0, 2'd0, 16'h0, w);
    check("t6_R1", 64'(bank[1]), 64'(16'h5A5A));
    run_cmd(3'd0, 2'd2, 2'd3, 16'hFFFF, 1'b0, 3'd0, 2'd0, 16'h0, w);

    // Random command mix with occasional edge-value presets
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       preset($urandom_range(0, 3), 16'hFFFF);
          1:       preset($urandom_range(0, 3), 16'h0000);
          default: preset($urandom_range(0, 3), 16'($urandom));
        endcase
      end
      rop   = 3'($urandom_range(0, 7));
      rdata = 16'($urandom);
      run_cmd(rop, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rdata,
              1'b0, 3'd0, 2'd0, 16'h0, w);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
